keypad_scan_ctrl: RTL and testbench

Sequencing controller for the 4x4 matrix keypad path. It sits between the row synchronizer and the digit memory. It drives the column scan, detects a single pressed key, debounces press and release, and emits exactly one key_valid pulse with a hex key code per physical press. It replaces free-running scan plus ad-hoc decode with one FSM that owns the column lines.

---
 rtl/keypad_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: drives one-cold columns, debounces a single key's press and release,
// and emits one key_valid pulse with the mapped hex code per physical press.
module keypad_scan_ctrl #(
   parameter int SCAN_CYCLES = 4,
   parameter int DB_CYCLES   = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] R,
   output logic [3:0] C,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       multi_err
);
   localparam int CNT_MAX = (SCAN_CYCLES > DB_CYCLES) ? SCAN_CYCLES : DB_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SCAN_CYCLES - 1);
   localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

   state_t        state;
   logic [1:0]    col_idx;
   logic [1:0]    row_idx;
   logic [3:0]    row_pat;
   logic [CW-1:0] settle_cnt;
   logic [CW-1:0] db_cnt;
   logic [2:0]    low_cnt;
   logic [1:0]    low_row;

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      case ({row, col})
         4'h0: key_map = 4'h1;
         4'h1: key_map = 4'h2;
         4'h2: key_map = 4'h3;
         4'h3: key_map = 4'hA;
         4'h4: key_map = 4'h4;
         4'h5: key_map = 4'h5;
         4'h6: key_map = 4'h6;
         4'h7: key_map = 4'hB;
         4'h8: key_map = 4'h7;
         4'h9: key_map = 4'h8;
         4'hA: key_map = 4'h9;
         4'hB: key_map = 4'hC;
         4'hC: key_map = 4'hE;
         4'hD: key_map = 4'h0;
         4'hE: key_map = 4'hF;
         4'hF: key_map = 4'hD;
      endcase
   endfunction

   // low_row is only meaningful when exactly one row is pulled low
   always_comb begin
      low_cnt = 3'd0;
      low_row = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!R[i]) begin
            low_cnt = low_cnt + 3'd1;
            low_row = 2'(i);
         end
      end
   end

   assign C = ~(4'b0001 << col_idx);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= SCAN;
         col_idx    <= 2'd0;
         row_idx    <= 2'd0;
         row_pat    <= 4'hF;
         settle_cnt <= '0;
         db_cnt     <= '0;
         key_code   <= 4'h0;
         key_valid  <= 1'b0;
         multi_err  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         multi_err <= 1'b0;
         case (state)
            SCAN: begin
               if (settle_cnt != SETTLE_LAST) begin
                  settle_cnt <= settle_cnt + 1'b1;
               end else begin
                  settle_cnt <= '0;
                  if (low_cnt == 3'd1) begin
                     row_idx <= low_row;
                     row_pat <= R;
                     db_cnt  <= '0;
                     state   <= DEBOUNCE;
                  end else begin
                     col_idx   <= col_idx + 2'd1;
                     multi_err <= (low_cnt > 3'd1);
                  end
               end
            end
            DEBOUNCE: begin
               if (R != row_pat) begin
                  settle_cnt <= '0;
                  db_cnt     <= '0;
                  state      <= SCAN;
               end else if (db_cnt == DB_LAST) begin
                  key_code  <= key_map(row_idx, col_idx);
                  key_valid <= 1'b1;
                  db_cnt    <= '0;
                  state     <= HOLD;
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (R == 4'hF) begin
                  db_cnt <= '0;
                  state  <= RELEASE;
               end
            end
            RELEASE: begin
               // a returning contact on the held row is release bounce, not a new press
               if (!R[row_idx]) begin
                  db_cnt <= '0;
                  state  <= HOLD;
               end else if (R == 4'hF) begin
                  if (db_cnt == DB_LAST) begin
                     col_idx    <= col_idx + 2'd1;
                     settle_cnt <= '0;
                     db_cnt     <= '0;
                     state      <= SCAN;
                  end else begin
                     db_cnt <= db_cnt + 1'b1;
                  end
               end else begin
                  db_cnt <= '0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad contact model drives R from C; expected outputs per
// cycle come from scan-position arithmetic and the press/debounce/release timing rules.
module tb_keypad_scan_ctrl;
   localparam int SCAN = 2;
   localparam int DB   = 4;
   localparam int N    = 600;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] row_mask = 4'h0;
   logic [1:0] key_col = 2'd0;
   logic [3:0] R;
   logic [3:0] C;
   logic [3:0] key_code;
   logic       key_valid;
   logic       multi_err;

   // physical keypad: a closed contact pulls its row low only while its column is driven
   assign R = (C[key_col] == 1'b0) ? ~row_mask : 4'hF;

   keypad_scan_ctrl #(.SCAN_CYCLES(SCAN), .DB_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .R(R), .C(C),
      .key_code(key_code), .key_valid(key_valid), .multi_err(multi_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [63:0] key_tbl = 64'h123A_456B_789C_E0FD;

   logic [3:0] pl_mask [N];
   logic [1:0] pl_col  [N];
   logic [9:0] exp_o   [N];   // {C, key_code, key_valid, multi_err}
   logic [9:0] obs     [N];
   int         org_t, org_c, t_now;
   logic [3:0] cur_code;

   function automatic logic [3:0] key_of(input int row, input int col);
      int idx;
      idx = row * 4 + col;
      return key_tbl[63 - 4 * idx -: 4];
   endfunction

   function automatic int scan_col(input int n);
      return (org_c + (n - org_t) / SCAN) % 4;
   endfunction

   function automatic int next_sample(input int from, input int col);
      for (int n = from; n < from + 8 * SCAN; n++)
         if ((n - org_t) % SCAN == SCAN - 1 && scan_col(n) == col) return n;
      return from;
   endfunction

   task automatic plan_clear();
      for (int i = 0; i < N; i++) begin
         pl_mask[i] = 4'h0;
         pl_col[i]  = 2'd0;
         exp_o[i]   = 10'h0;
      end
      org_t = 0; org_c = 0; t_now = 0; cur_code = 4'h0;
   endtask

   task automatic fill(input int from, input int to, input int fixed_col);
      logic [1:0] cc;
      for (int n = from; n < to && n < N; n++) begin
         cc = 2'((fixed_col < 0) ? scan_col(n) : fixed_col);
         exp_o[n] = {~(4'b0001 << cc), cur_code, 2'b00};
      end
   endtask

   task automatic set_contact(input int from, input int to, input int row, input int col);
      for (int n = from; n < to && n < N; n++) begin
         pl_mask[n] = 4'(1 << row);
         pl_col[n]  = 2'(col);
      end
   endtask

   task automatic plan_idle(input int len);
      fill(t_now, t_now + len, -1);
      t_now += len;
   endtask

   task automatic plan_multi(input int col, input logic [3:0] mask, input int gap);
      int s;
      s = next_sample(t_now + gap, col);
      fill(t_now, s + 2, -1);
      pl_mask[s] = mask;
      pl_col[s]  = 2'(col);
      exp_o[s + 1][0] = 1'b1;
      t_now = s + 2;
   endtask

   // pressed key is accepted DB+1 cycles after its detecting sample; resume DB+1 after final release
   task automatic plan_press(input int row, input int col, input int gap, input bit pbounce,
                             input int hold, input int nrel, input bit rand_len, output int pulse_at);
      int p, s0, s, t, a, b;
      p  = t_now + gap;
      s0 = next_sample(p, col);
      if (pbounce) begin
         fill(t_now, s0 + 1, -1);
         fill(s0 + 1, s0 + 4, col);
         set_contact(p, s0 + 1, row, col);
         set_contact(s0 + 2, s0 + 3, row, col);
         set_contact(s0 + 4, s0 + 5, row, col);
         org_t = s0 + 4; org_c = (col + 1) % 4;
         s = next_sample(s0 + 6, col);
         fill(s0 + 4, s + 1, -1);
         p = s0 + 6;
      end else begin
         s = s0;
         fill(t_now, s + 1, -1);
      end
      fill(s + 1, s + DB + 1, col);
      pulse_at = s + DB + 1;
      t = pulse_at + hold;
      set_contact(p, t, row, col);
      for (int i = 0; i < nrel; i++) begin
         a = rand_len ? int'($urandom_range(1, DB)) : 1;
         b = rand_len ? int'($urandom_range(1, 3)) : 1;
         set_contact(t + a, t + a + b, row, col);
         t += a + b;
      end
      cur_code = key_of(row, col);
      fill(pulse_at, t + DB + 1, col);
      exp_o[pulse_at][1] = 1'b1;
      org_t = t + DB + 1; org_c = (col + 1) % 4; t_now = org_t;
   endtask

   task automatic run_plan(input int upto);
      reset = 1'b1;
      row_mask = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < upto; n++) begin
         row_mask = pl_mask[n];
         key_col  = pl_col[n];
         obs[n] = {C, key_code, key_valid, multi_err};
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      checks++; if (C !== 4'b1110) begin failures++; $display("FAIL reset_C got=%b want=1110", C); end
      checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h want=0", key_code); end
      checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_kv got=%b want=0", key_valid); end
      checks++; if (multi_err !== 1'b0) begin failures++; $display("FAIL reset_me got=%b want=0", multi_err); end
   endtask

   task automatic test_idle();
      plan_clear();
      plan_idle(40);
      run_plan(t_now);
      for (int n = 0; n < t_now; n++) begin
         checks++;
         if (obs[n] !== exp_o[n]) begin
            failures++;
            $display("FAIL idle cyc=%0d got=%b want=%b (C,code,kv,me)", n, obs[n], exp_o[n]);
         end
      end
   endtask

   task automatic test_clean_press();
      int row, col, pa, first, np;
      for (int k = 0; k < 4; k++) begin
         row = (k == 0) ? 1 : int'($urandom_range(0, 3));
         col = (k == 0) ? 2 : int'($urandom_range(0, 3));
         plan_clear();
         plan_press(row, col, (k == 0) ? 0 : int'($urandom_range(0, 10)), 1'b0,
                    (k == 0) ? 20 : int'($urandom_range(1, 10)), 0, 1'b0, pa);
         plan_idle(10);
         run_plan(t_now);
         first = -1; np = 0;
         for (int n = 0; n < t_now; n++) begin
            if (obs[n][1] === 1'b1) begin np++; if (first < 0) first = n; end
            checks++;
            if (obs[n] !== exp_o[n]) begin
               failures++;
               $display("FAIL press key=%h cyc=%0d got=%b want=%b (C,code,kv,me)", key_of(row, col), n, obs[n], exp_o[n]);
            end
         end
         checks++; if (np !== 1) begin failures++; $display("FAIL press_pulses got=%0d want=1", np); end
         checks++; if (first !== pa) begin failures++; $display("FAIL press_latency got=%0d want=%0d", first, pa); end
      end
   endtask

   task automatic test_press_bounce();
      int row, col, pa, np;
      for (int k = 0; k < 2; k++) begin
         row = (k == 0) ? 1 : int'($urandom_range(0, 3));
         col = (k == 0) ? 2 : int'($urandom_range(0, 3));
         plan_clear();
         plan_press(row, col, int'($urandom_range(0, 6)), 1'b1, 6, 0, 1'b0, pa);
         plan_idle(8);
         run_plan(t_now);
         np = 0;
         for (int n = 0; n < t_now; n++) begin
            if (obs[n][1] === 1'b1) np++;
            checks++;
            if (obs[n] !== exp_o[n]) begin
               failures++;
               $display("FAIL press_bounce cyc=%0d got=%b want=%b (C,code,kv,me)", n, obs[n], exp_o[n]);
            end
         end
         checks++; if (np !== 1) begin failures++; $display("FAIL press_bounce_pulses got=%0d want=1", np); end
      end
   endtask

   task automatic test_release_bounce();
      int row, col, pa, np;
      for (int k = 0; k < 3; k++) begin
         row = (k == 0) ? 3 : int'($urandom_range(0, 3));
         col = (k == 0) ? 1 : int'($urandom_range(0, 3));
         plan_clear();
         plan_press(row, col, 1, 1'b0, 5, (k == 0) ? 1 : 3, k != 0, pa);
         plan_idle(10);
         run_plan(t_now);
         np = 0;
         for (int n = 0; n < t_now; n++) begin
            if (obs[n][1] === 1'b1) np++;
            checks++;
            if (obs[n] !== exp_o[n]) begin
               failures++;
               $display("FAIL release_bounce cyc=%0d got=%b want=%b (C,code,kv,me)", n, obs[n], exp_o[n]);
            end
         end
         checks++; if (np !== 1) begin failures++; $display("FAIL release_bounce_pulses got=%0d want=1", np); end
      end
   endtask

   task automatic test_multi_key();
      int r1, r2, pa, nme;
      plan_clear();
      plan_multi(0, 4'b0011, 0);
      r1 = int'($urandom_range(0, 3));
      r2 = (r1 + int'($urandom_range(1, 3))) % 4;
      plan_multi(int'($urandom_range(0, 3)), 4'((1 << r1) | (1 << r2)), int'($urandom_range(0, 6)));
      plan_press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2, 1'b0, 3, 0, 1'b0, pa);
      plan_idle(6);
      run_plan(t_now);
      nme = 0;
      for (int n = 0; n < t_now; n++) begin
         if (obs[n][0] === 1'b1) nme++;
         checks++;
         if (obs[n] !== exp_o[n]) begin
            failures++;
            $display("FAIL multi cyc=%0d got=%b want=%b (C,code,kv,me)", n, obs[n], exp_o[n]);
         end
      end
      checks++; if (nme !== 2) begin failures++; $display("FAIL multi_err_pulses got=%0d want=2", nme); end
   endtask

   task automatic test_back_to_back();
      int pa, np;
      plan_clear();
      for (int k = 0; k < 3; k++)
         plan_press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    1'b0, int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 1'b1, pa);
      plan_idle(6);
      run_plan(t_now);
      np = 0;
      for (int n = 0; n < t_now; n++) begin
         if (obs[n][1] === 1'b1) np++;
         checks++;
         if (obs[n] !== exp_o[n]) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got=%b want=%b (C,code,kv,me)", n, obs[n], exp_o[n]);
         end
      end
      checks++; if (np !== 3) begin failures++; $display("FAIL back_to_back_pulses got=%0d want=3", np); end
   endtask

   task automatic test_async_reset();
      int pa, pb, abort_at;
      plan_clear();
      plan_press(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 3, 1'b0, 4, 0, 1'b0, pa);
      plan_press(3, 2, 2, 1'b0, 20, 0, 1'b0, pb);
      abort_at = pb - 3;
      run_plan(abort_at);
      for (int n = 0; n < abort_at; n++) begin
         checks++;
         if (obs[n] !== exp_o[n]) begin
            failures++;
            $display("FAIL pre_abort cyc=%0d got=%b want=%b (C,code,kv,me)", n, obs[n], exp_o[n]);
         end
      end
      #1 reset = 1'b1;
      #1;
      checks++; if (C !== 4'b1110) begin failures++; $display("FAIL abort_C got=%b want=1110", C); end
      checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL abort_code got=%h want=0", key_code); end
      checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL abort_kv got=%b want=0", key_valid); end
      plan_clear();
      plan_idle(30);
      run_plan(t_now);
      for (int n = 0; n < t_now; n++) begin
         checks++;
         if (obs[n] !== exp_o[n]) begin
            failures++;
            $display("FAIL post_abort cyc=%0d got=%b want=%b (C,code,kv,me)", n, obs[n], exp_o[n]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_clean_press();
      test_press_bounce();
      test_release_bounce();
      test_multi_key();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
